fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline; direct consumer of the taken-branch signal br_ctrl.
- Owns the PC register and drives the instruction-memory address.
- Holds the IF/ID pipeline register and applies redirect, stall, flush and halt sequencing before instructions reach decode.

Parameters:
PC_W, 16, width of PC, instruction word and all address/target buses
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0000, instruction word inserted into IF/ID on a bubble (encoding has no architectural effect)
HLT_OP, 4'b1111, opcode (bits [15:12]) that starts halt sequencing

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst  input  1  synchronous, active-high reset
br_ctrl  input  1  taken conditional/unconditional branch resolved downstream this cycle
br_target  input  PC_W  branch destination, valid when br_ctrl=1
jmp  input  1  register/immediate jump resolved downstream this cycle
jmp_target  input  PC_W  jump destination, valid when jmp=1
stall  input  1  hazard unit: hold PC and IF/ID contents
hlt_retire  input  1  HLT instruction has reached write-back
imem_addr  output  PC_W  instruction-memory address, equals current PC
imem_data  input  PC_W  instruction word at imem_addr, combinational read, same cycle
ifid_instr  output  PC_W  instruction presented to decode
ifid_pc_inc  output  PC_W  address of that instruction + 1
ifid_valid  output  1  ifid_instr is a real instruction, not a bubble
halted  output  1  processor fully stopped

Behaviour:
- Reset (rst=1 at an edge): PC=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_inc=0, ifid_valid=0, state=RUN, halted=0. Reset overrides every other input. Reset asserted mid-operation (any state) behaves identically.
- imem_addr = PC, combinational. Fetch latency is one cycle: the word at PC appears on ifid_instr after the next edge.
- States: RUN, HALT_PEND, HALTED. halted=1 only in HALTED.
- Redirect = br_ctrl | jmp. If both are asserted, br_ctrl wins (br_target is used).
- Per-edge priority, all states except HALTED:
  1. redirect: PC <= target; IF/ID <= {NOP_INSTR, 0, valid=0}, flushing the wrong-path instruction. Takes effect even when stall=1. In HALT_PEND, also returns state to RUN, because the HLT was on the wrong path.
  2. stall: PC and all IF/ID fields hold.
  3. normal, RUN state: IF/ID <= {imem_data, PC+1, valid=1}.
     - If imem_data[15:12]==HLT_OP, PC holds and state moves to HALT_PEND.
     - Otherwise PC <= PC+1.
  4. normal, HALT_PEND state: PC holds; IF/ID <= bubble (valid=0). No further fetches enter the pipe.
- HALT_PEND to HALTED occurs on hlt_retire=1, unless redirect is asserted in the same cycle (redirect wins).
- HALTED: PC, IF/ID and state frozen until rst. br_ctrl, jmp, stall and hlt_retire are ignored.
- PC+1 arithmetic is modulo 2^PC_W: 16'hFFFF increments to 16'h0000 with no flag. The same wrap applies to ifid_pc_inc.
- No combinational path exists from br_ctrl/jmp/stall to any IF/ID output. The only combinational output is imem_addr, which comes from the PC register.

Test Plan:
- Reset, then 4 free-running cycles with imem returning 16'h1234 -> imem_addr sequence 0,1,2,3,4. ifid_pc_inc = 1,2,3,4. ifid_valid=1 from the first edge after reset.
- At PC=5, br_ctrl=1 and br_target=16'h0040 -> next cycle imem_addr=16'h0040 and ifid_valid=0. The following cycle ifid_pc_inc=16'h0041 and ifid_valid=1.
- stall=1 for 3 cycles at PC=7 -> imem_addr stays 7 and IF/ID is unchanged. Repeat with br_ctrl=1 and br_target=16'h0100 during the stall -> PC=16'h0100 and ifid_valid=0.
- br_ctrl=1 (target 16'h0020) together with jmp=1 (target 16'h0030) -> PC=16'h0020.
- Fetch HLT (16'hF000) at PC=9 -> PC stays 9 and later ifid_valid=0. Driving hlt_retire=1 -> halted=1 next cycle. Driving br_ctrl while halted -> no change. Asserting rst -> PC=0 and halted=0.
- HLT fetched, then br_ctrl=1 (target 16'h0050) while in HALT_PEND -> state returns to RUN, PC=16'h0050 and halted stays 0. Separately, PC=16'hFFFF in normal flow -> next PC=16'h0000 and ifid_pc_inc=16'h0000.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, instruction fetch and IF/ID register with redirect, stall, flush and halt sequencing
module fetch_pc_unit #(
   parameter int PC_W = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [PC_W-1:0] NOP_INSTR = '0,
   parameter logic [3:0] HLT_OP = 4'b1111
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_ctrl,
   input  logic [PC_W-1:0] br_target,
   input  logic            jmp,
   input  logic [PC_W-1:0] jmp_target,
   input  logic            stall,
   input  logic            hlt_retire,
   output logic [PC_W-1:0] imem_addr,
   input  logic [PC_W-1:0] imem_data,
   output logic [PC_W-1:0] ifid_instr,
   output logic [PC_W-1:0] ifid_pc_inc,
   output logic            ifid_valid,
   output logic            halted
);
   typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;
   state_t state, state_n;
   logic [PC_W-1:0] pc, pc_n, instr_n, pc_inc_n, pc_plus;
   logic valid_n, redirect;
   assign imem_addr = pc;
   assign halted = state == HALTED;
   assign pc_plus = pc + 1'b1;
   assign redirect = br_ctrl | jmp;
   always_comb begin
      state_n = state;
      pc_n = pc;
      instr_n = ifid_instr;
      pc_inc_n = ifid_pc_inc;
      valid_n = ifid_valid;
      if (state != HALTED) begin
         if (redirect) begin
            pc_n = br_ctrl ? br_target : jmp_target;
            instr_n = NOP_INSTR;
            pc_inc_n = '0;
            valid_n = 1'b0;
            state_n = RUN;
         end else begin
            if (state == HALT_PEND && hlt_retire) state_n = HALTED;
            if (!stall && state == RUN) begin
               instr_n = imem_data;
               pc_inc_n = pc_plus;
               valid_n = 1'b1;
               state_n = imem_data[PC_W-1 -: 4] == HLT_OP ? HALT_PEND : RUN;
               pc_n = imem_data[PC_W-1 -: 4] == HLT_OP ? pc : pc_plus;
            end else if (!stall) begin
               instr_n = NOP_INSTR;
               pc_inc_n = '0;
               valid_n = 1'b0;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         pc <= RESET_PC;
         ifid_instr <= NOP_INSTR;
         ifid_pc_inc <= '0;
         ifid_valid <= 1'b0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         ifid_instr <= instr_n;
         ifid_pc_inc <= pc_inc_n;
         ifid_valid <= valid_n;
      end
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vectors with a queue-based scoreboard checking every post-edge state
module tb_fetch_pc_unit;
   logic clk = 0, rst = 1, br_ctrl = 0, jmp = 0, stall = 0, hlt_retire = 0;
   logic [15:0] br_target = 0, jmp_target = 0, imem_data = 16'h1234;
   logic [15:0] imem_addr, ifid_instr, ifid_pc_inc;
   logic ifid_valid, halted;
   logic [49:0] exp_q[$];
   int checks = 0, failures = 0, step_n = 0;

   fetch_pc_unit dut (
      .clk(clk), .rst(rst), .br_ctrl(br_ctrl), .br_target(br_target), .jmp(jmp),
      .jmp_target(jmp_target), .stall(stall), .hlt_retire(hlt_retire),
      .imem_addr(imem_addr), .imem_data(imem_data), .ifid_instr(ifid_instr),
      .ifid_pc_inc(ifid_pc_inc), .ifid_valid(ifid_valid), .halted(halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [49:0] e, a;
         e = exp_q.pop_front();
         a = {imem_addr, ifid_instr, ifid_pc_inc, ifid_valid, halted};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL step%0d got pc=%h instr=%h inc=%h v=%b h=%b expected pc=%h instr=%h inc=%h v=%b h=%b",
                     step_n, a[49:34], a[33:18], a[17:2], a[1], a[0], e[49:34], e[33:18], e[17:2], e[1], e[0]);
         end
         step_n++;
      end
   end

   task automatic step(input logic r, input logic b, input logic [15:0] bt, input logic j,
                       input logic [15:0] jt, input logic s, input logic hr, input logic [15:0] im,
                       input logic [15:0] e_pc, input logic [15:0] e_in, input logic [15:0] e_inc,
                       input logic e_v, input logic e_h);
      @(negedge clk);
      rst = r; br_ctrl = b; br_target = bt; jmp = j; jmp_target = jt;
      stall = s; hlt_retire = hr; imem_data = im;
      exp_q.push_back({e_pc, e_in, e_inc, e_v, e_h});
   endtask

   initial begin
      //   rst br  bt       jmp jt       st hr imem     | pc       instr    inc      v  h
      step(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 16'h0001, 16'h1234, 16'h0001, 1, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 16'h0003, 16'h1234, 16'h0003, 1, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 16'h0004, 16'h1234, 16'h0004, 1, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 16'h0005, 16'h1234, 16'h0005, 1, 0);
      step(0, 1, 16'h0040, 0, 16'h0000, 0, 0, 16'h1234, 16'h0040, 16'h0000, 16'h0000, 0, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 16'h0041, 16'h1234, 16'h0041, 1, 0);
      step(0, 0, 16'h0000, 1, 16'h0006, 0, 0, 16'h1234, 16'h0006, 16'h0000, 16'h0000, 0, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h5A5A, 16'h0007, 16'h5A5A, 16'h0007, 1, 0);
      for (int i = 0; i < 3; i++)
         step(0, 0, 16'h0000, 0, 16'h0000, 1, 0, 16'h7777, 16'h0007, 16'h5A5A, 16'h0007, 1, 0);
      step(0, 1, 16'h0100, 0, 16'h0000, 1, 0, 16'h7777, 16'h0100, 16'h0000, 16'h0000, 0, 0);
      step(0, 1, 16'h0020, 1, 16'h0030, 0, 0, 16'h1234, 16'h0020, 16'h0000, 16'h0000, 0, 0);
      step(0, 0, 16'h0000, 1, 16'h0009, 0, 0, 16'h1234, 16'h0009, 16'h0000, 16'h0000, 0, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'hF000, 16'h0009, 16'hF000, 16'h000A, 1, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 16'h0009, 16'h0000, 16'h0000, 0, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h1234, 16'h0009, 16'h0000, 16'h0000, 0, 1);
      step(0, 1, 16'h0040, 0, 16'h0000, 0, 0, 16'h5A5A, 16'h0009, 16'h0000, 16'h0000, 0, 1);
      step(0, 0, 16'h0000, 1, 16'h0033, 1, 1, 16'h1234, 16'h0009, 16'h0000, 16'h0000, 0, 1);
      step(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'hF000, 16'h0000, 16'hF000, 16'h0001, 1, 0);
      step(0, 1, 16'h0050, 0, 16'h0000, 0, 1, 16'h1234, 16'h0050, 16'h0000, 16'h0000, 0, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 16'h0051, 16'h1234, 16'h0051, 1, 0);
      step(0, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000, 0, 0);
      step(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 1, 0);
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
